// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory stage: access codes, FSM states,
// and the alignment / byte-lane helpers used by the store path.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        MOP_W  = 3'b000,
        MOP_H  = 3'b001,
        MOP_HU = 3'b010,
        MOP_B  = 3'b011,
        MOP_BU = 3'b100
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [3:0] LANES_ALL     = 4'b1111;
    localparam logic [3:0] LANES_LO_HALF = 4'b0011;
    localparam logic [3:0] LANES_BYTE0   = 4'b0001;

    // Unknown codes behave like a word access.
    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MOP_H, MOP_HU: return !off[0];
            MOP_B, MOP_BU: return 1'b1;
            default:       return off == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MOP_H, MOP_HU: return LANES_LO_HALF << {off[1], 1'b0};
            MOP_B, MOP_BU: return LANES_BYTE0 << off;
            default:       return LANES_ALL;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load extractor: picks the addressed byte/half out of a little-endian word
// and sign- or zero-extends it to 32 bits.
module dm_load_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [15:0] half_w;
    logic [7:0]  byte_w;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        half_w = 16'(word_i >> {byte_off_i[1], 4'b0000});
        byte_w = 8'(word_i >> {byte_off_i, 3'b000});
        data_o = word_i;
        case (op_i)
            MOP_H:   data_o = {{16{half_w[15]}}, half_w};
            MOP_HU:  data_o = {16'h0000, half_w};
            MOP_B:   data_o = {{24{byte_w[7]}}, byte_w};
            MOP_BU:  data_o = {24'h000000, byte_w};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: word-organised data memory with
// sub-word loads/stores, a wait-state counter and a pipeline stall output.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memOp,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        addrError
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    read_data_q, read_data_d;
    logic           wr_q;
    logic [2:0]     op_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           req, req_ok, commit;
    logic [31:0]    load_ext;
    logic [31:0]    lane_data;
    logic [3:0]     lane_sel;
    logic           unused_addr_hi;

    // Upper address bits wrap away by design.
    assign unused_addr_hi = ^addr[31:AW+2];

    assign req    = memRead | memWrite;
    assign req_ok = req & is_aligned(memOp, addr[1:0]);
    assign commit = (state_q == BUSY) && (cnt_q == '0);

    dm_load_ext u_load_ext (
        .word_i     (mem_q[addr_q[AW+1:2]]),
        .byte_off_i (addr_q[1:0]),
        .op_i       (op_q),
        .data_o     (load_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        stall       = 1'b0;
        addrError   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    stall   = 1'b1;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    state_d = BUSY;
                end else if (req) begin
                    addrError   = 1'b1;
                    read_data_d = '0;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    if (!wr_q) read_data_d = load_ext;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            wr_q        <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            if (state_q == IDLE && req_ok) begin
                wr_q    <= memWrite;
                op_q    <= memOp;
                addr_q  <= addr[AW+1:0];
                wdata_q <= writeData;
            end
        end
    end

    always_comb begin
        lane_sel  = lane_mask(op_q, addr_q[1:0]);
        lane_data = wdata_q;
        case (op_q)
            MOP_H, MOP_HU: lane_data = {2{wdata_q[15:0]}};
            MOP_B, MOP_BU: lane_data = {4{wdata_q[7:0]}};
            default:       lane_data = wdata_q;
        endcase
    end

    // NOTE: the memory array has no reset; contents survive rst, and a store
    // only commits from BUSY, so an aborted access never touches it.
    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_sel[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign readData = read_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=3; expected load results flow through a scoreboard queue.
module tb_mem_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst1_n, rst3_n;
    logic        sel;
    logic        rd, wr;
    logic [2:0]  op;
    logic [31:0] a, wd;

    logic [31:0] rdata1, rdata3;
    logic        stall1, stall3, aerr1, aerr3;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        string       name;
        logic        is_rd;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } acc_t;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst1_n),
        .memRead   (rd & ~sel),
        .memWrite  (wr & ~sel),
        .memOp     (op),
        .addr      (a),
        .writeData (wd),
        .readData  (rdata1),
        .stall     (stall1),
        .addrError (aerr1)
    );

    mem_stage #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst3_n),
        .memRead   (rd & sel),
        .memWrite  (wr & sel),
        .memOp     (op),
        .addr      (a),
        .writeData (wd),
        .readData  (rdata3),
        .stall     (stall3),
        .addrError (aerr3)
    );

    function automatic logic cur_stall();
        return sel ? stall3 : stall1;
    endfunction

    function automatic logic [31:0] cur_rdata();
        return sel ? rdata3 : rdata1;
    endfunction

    // Presents one request in IDLE, counts stalled cycles, returns readData seen in DONE.
    task automatic run_access(input logic s, input logic is_rd, input logic [2:0] o,
                              input logic [31:0] ad, input logic [31:0] d,
                              output int ncyc, output logic [31:0] rd_done);
        @(negedge clk);
        sel = s; rd = is_rd; wr = ~is_rd; op = o; a = ad; wd = d;
        #1;
        ncyc = 0;
        while (cur_stall() && ncyc < 40) begin
            ncyc++;
            @(negedge clk);
            #1;
        end
        rd_done = cur_rdata();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst3_n = 1'b0;
        sel = 1'b0; rd = 1'b0; wr = 1'b0; op = MOP_W; a = '0; wd = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0); end
        vectors++; if (stall1 !== 1'b0) begin miscompares++; $display("FAIL reset_stall1: got %b expected 0", stall1); end
        vectors++; if (aerr1 !== 1'b0) begin miscompares++; $display("FAIL reset_aerr1: got %b expected 0", aerr1); end
        vectors++; if (rdata3 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata3: got %h expected %h", rdata3, 32'h0); end
        @(negedge clk);
        rst1_n = 1'b1; rst3_n = 1'b1;
        #1;
        vectors++; if (stall3 !== 1'b0) begin miscompares++; $display("FAIL reset_stall3: got %b expected 0", stall3); end
    endtask

    task automatic test_load_store();
        acc_t        tbl [12];
        int          n;
        logic [31:0] got, prev, expv;
        tbl[0]  = '{"SW_10",  1'b0, MOP_W,  32'h10, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{"LW_10",  1'b1, MOP_W,  32'h10, 32'h0, 32'hDEADBEEF};
        tbl[2]  = '{"LB_11",  1'b1, MOP_B,  32'h11, 32'h0, 32'hFFFFFFBE};
        tbl[3]  = '{"LBU_11", 1'b1, MOP_BU, 32'h11, 32'h0, 32'h000000BE};
        tbl[4]  = '{"LH_12",  1'b1, MOP_H,  32'h12, 32'h0, 32'hFFFFDEAD};
        tbl[5]  = '{"LHU_10", 1'b1, MOP_HU, 32'h10, 32'h0, 32'h0000BEEF};
        tbl[6]  = '{"SB_13",  1'b0, MOP_B,  32'h13, 32'hAAAAAA55, 32'h0};
        tbl[7]  = '{"LW_sb",  1'b1, MOP_W,  32'h10, 32'h0, 32'h55ADBEEF};
        tbl[8]  = '{"SH_10",  1'b0, MOP_H,  32'h10, 32'hFFFF1234, 32'h0};
        tbl[9]  = '{"LW_sh",  1'b1, MOP_W,  32'h10, 32'h0, 32'h55AD1234};
        tbl[10] = '{"LB_10",  1'b1, MOP_B,  32'h10, 32'h0, 32'h00000034};
        tbl[11] = '{"LH_pos", 1'b1, MOP_H,  32'h12, 32'h0, 32'h000055AD};
        foreach (tbl[i]) begin
            prev = rdata1;
            if (tbl[i].is_rd) exp_q.push_back(tbl[i].exp);
            run_access(1'b0, tbl[i].is_rd, tbl[i].op, tbl[i].addr, tbl[i].data, n, got);
            vectors++;
            if (n !== 2) begin miscompares++; $display("FAIL %s_stall_cycles: got %0d expected 2", tbl[i].name, n); end
            expv = tbl[i].is_rd ? exp_q.pop_front() : prev;
            vectors++;
            if (got !== expv) begin miscompares++; $display("FAIL %s_rdata: got %h expected %h", tbl[i].name, got, expv); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_stall;
        logic [31:0] expv;
        @(negedge clk);
        sel = 1'b0; rd = 1'b1; wr = 1'b0; op = MOP_W; a = 32'h10;
        exp_q.push_back(32'h55AD1234);
        #1;
        for (int c = 0; c < 6; c++) begin
            exp_stall = (c % 3) != 2;
            vectors++;
            if (stall1 !== exp_stall) begin miscompares++; $display("FAIL b2b_stall_c%0d: got %b expected %b", c, stall1, exp_stall); end
            if (c == 1) begin op = MOP_BU; a = 32'h13; end
            if (c == 2 || c == 5) begin
                expv = exp_q.pop_front();
                vectors++;
                if (rdata1 !== expv) begin miscompares++; $display("FAIL b2b_rdata_c%0d: got %h expected %h", c, rdata1, expv); end
                if (c == 2) exp_q.push_back(32'h00000055);
            end
            if (c == 5) rd = 1'b0;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_misaligned();
        acc_t        tbl [3];
        int          n;
        logic [31:0] got;
        tbl[0] = '{"mis_LW_02", 1'b1, MOP_W, 32'h02, 32'h0, 32'h0};
        tbl[1] = '{"mis_LH_01", 1'b1, MOP_H, 32'h01, 32'h0, 32'h0};
        tbl[2] = '{"mis_SW_11", 1'b0, MOP_W, 32'h11, 32'hFFFFFFFF, 32'h0};
        foreach (tbl[i]) begin
            @(negedge clk);
            sel = 1'b0; rd = tbl[i].is_rd; wr = ~tbl[i].is_rd; op = tbl[i].op; a = tbl[i].addr; wd = tbl[i].data;
            #1;
            vectors++; if (aerr1 !== 1'b1) begin miscompares++; $display("FAIL %s_aerr: got %b expected 1", tbl[i].name, aerr1); end
            vectors++; if (stall1 !== 1'b0) begin miscompares++; $display("FAIL %s_stall: got %b expected 0", tbl[i].name, stall1); end
            @(posedge clk);
            #1;
            rd = 1'b0; wr = 1'b0;
            @(negedge clk);
            #1;
            vectors++; if (aerr1 !== 1'b0) begin miscompares++; $display("FAIL %s_aerr_pulse: got %b expected 0", tbl[i].name, aerr1); end
            vectors++; if (rdata1 !== tbl[i].exp) begin miscompares++; $display("FAIL %s_rdata: got %h expected %h", tbl[i].name, rdata1, tbl[i].exp); end
        end
        exp_q.push_back(32'h55AD1234);
        run_access(1'b0, 1'b1, MOP_W, 32'h10, 32'h0, n, got);
        vectors++;
        if (got !== exp_q[0]) begin miscompares++; $display("FAIL mis_mem_unchanged: got %h expected %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid_access();
        int          n;
        logic [31:0] got, expv;
        run_access(1'b1, 1'b0, MOP_W, 32'h20, 32'h01020304, n, got);
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL w3_sw_stall_cycles: got %0d expected 4", n); end
        exp_q.push_back(32'h01020304);
        run_access(1'b1, 1'b1, MOP_W, 32'h20, 32'h0, n, got);
        expv = exp_q.pop_front();
        vectors++; if (got !== expv) begin miscompares++; $display("FAIL w3_lw_rdata: got %h expected %h", got, expv); end
        @(negedge clk);
        sel = 1'b1; rd = 1'b0; wr = 1'b1; op = MOP_W; a = 32'h20; wd = 32'hCAFEF00D;
        #1;
        vectors++; if (stall3 !== 1'b1) begin miscompares++; $display("FAIL w3_idle_stall: got %b expected 1", stall3); end
        @(negedge clk);
        #1;
        vectors++; if (stall3 !== 1'b1) begin miscompares++; $display("FAIL w3_busy_stall: got %b expected 1", stall3); end
        @(negedge clk);
        rst3_n = 1'b0; wr = 1'b0;
        #1;
        vectors++; if (stall3 !== 1'b0) begin miscompares++; $display("FAIL w3_rst_stall: got %b expected 0", stall3); end
        vectors++; if (rdata3 !== 32'h0) begin miscompares++; $display("FAIL w3_rst_rdata: got %h expected %h", rdata3, 32'h0); end
        @(negedge clk);
        rst3_n = 1'b1;
        exp_q.push_back(32'h01020304);
        run_access(1'b1, 1'b1, MOP_W, 32'h20, 32'h0, n, got);
        expv = exp_q.pop_front();
        vectors++; if (got !== expv) begin miscompares++; $display("FAIL w3_store_discarded: got %h expected %h", got, expv); end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL w3_lw_stall_cycles: got %0d expected 4", n); end
    endtask

    task automatic test_wrap();
        int          n;
        logic [31:0] got, expv;
        run_access(1'b0, 1'b0, MOP_W, 32'h1000, 32'h11111111, n, got);
        exp_q.push_back(32'h11111111);
        run_access(1'b0, 1'b1, MOP_W, 32'h0, 32'h0, n, got);
        expv = exp_q.pop_front();
        vectors++; if (got !== expv) begin miscompares++; $display("FAIL wrap_lw_0: got %h expected %h", got, expv); end
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL wrap_stall_cycles: got %0d expected 2", n); end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_access();
        test_wrap();
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory stage of the five-stage MIPS pipeline, between the EX/MEM register and the `mem_wb` register. It holds a word-organised data memory and performs sub-word loads and stores (word, half, byte; signed and unsigned loads) with a configurable wait-state count. While an access is in progress it raises `stall` to freeze the pipeline. The load result on `readData` feeds the `readData` input of the MEM/WB register.

## Interface
- `DEPTH_WORDS`, 1024: data-memory depth in 32-bit words (power of two).
- `WAIT_CYCLES`, 1: busy cycles per access (≥1).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `memRead`  in  1  load request from EX/MEM.
- `memWrite`  in  1  store request from EX/MEM (never asserted together with `memRead`).
- `memOp`  in  3  access size and sign (package codes).
- `addr`  in  32  byte address (ALU result).
- `writeData`  in  32  store data; the low byte or low half is used for sub-word stores.
- `readData`  out  32  registered load result, extended to 32 bits.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; suppress MEM/WB capture.
- `addrError`  out  1  one-cycle pulse on a misaligned access.

## Operation
- `memOp` codes:
  - W=000, H=001, HU=010, B=011, BU=100.
  - Stores use W, H or B only.
  - Any other code is treated as W.
- Alignment:
  - W requires `addr[1:0]`=00.
  - H and HU require `addr[0]`=0.
  - B and BU are always aligned.
- Byte order is little-endian: byte 0 is bits 7:0 of the word.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`; higher address bits are ignored, so addresses wrap modulo the memory size.
- Stores:
  - H writes lanes {1,0} when `addr[1]`=0 and lanes {3,2} when `addr[1]`=1.
  - B writes a single lane selected by `addr[1:0]`.
  - Lanes not selected are left unchanged.
- Loads:
  - H and B sign-extend; HU and BU zero-extend.
  - W returns the word unchanged.
- State machine, states IDLE, BUSY, DONE:
  - IDLE: if a request is present and aligned, load counter with WAIT_CYCLES−1 and go to BUSY; otherwise stay.
  - BUSY, counter≠0: decrement the counter.
  - BUSY, counter=0: commit the store, or register the extended load result into `readData`; go to DONE.
  - DONE: go to IDLE unconditionally. The pipeline advances at this edge.
- `stall` is combinational:
  - asserted in IDLE when an aligned request is present;
  - asserted throughout BUSY;
  - deasserted in DONE.
- Misaligned request seen in IDLE:
  - no memory access, no stall;
  - `readData` is forced to 0 at the next edge;
  - `addrError`=1 for that cycle only.
- `readData` holds its value outside access commits; non-load instructions see the stale value.
- Request signals are sampled only in IDLE. Changes during BUSY or DONE are ignored, because the pipeline is frozen.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `readData`=0, `stall`=0, `addrError`=0.
  - Memory contents are not cleared.
- An aligned request at cycle 0 (IDLE) gives `stall`=1 in cycles 0..WAIT_CYCLES and `stall`=0 in cycle WAIT_CYCLES+1 (DONE).
- Total stall cycles per access: WAIT_CYCLES+1.
- The store takes effect at the edge ending the last BUSY cycle.
- `readData` is valid in DONE and is captured by MEM/WB at the edge ending DONE.
- Back-to-back accesses: the next request is accepted in the IDLE cycle right after DONE; no access overlaps another.
- Reset asserted mid-access: return to IDLE immediately. An uncommitted store is discarded, with no partial lane writes.
- `addrError` is high only in the cycle the misaligned request is presented in IDLE.

## Structure
- Package `mips_mem_pkg` holds:
  - `memOp` codes;
  - the state enum (IDLE/BUSY/DONE);
  - alignment-check and lane-mask constants.
- Sub-module `dm_load_ext`: purely combinational. Takes word, `addr[1:0]` and `memOp`; produces the extended 32-bit result.
- The memory array, write-lane logic, counter and FSM live in `mem_stage`.

## Test plan
- SW 0xDEADBEEF at 0x10, then LW 0x10 (WAIT_CYCLES=1) → 2 stall cycles each; `readData`=0xDEADBEEF in DONE.
- After that word: LB 0x11 → 0xFFFFFFBE; LBU 0x11 → 0x000000BE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x55 at 0x13 over 0xDEADBEEF → LW 0x10 returns 0x55ADBEEF; SH 0x1234 at 0x10 → LW returns 0x55AD1234.
- LW 0x02 and LH 0x01 → `addrError` pulses 1 cycle, `stall`=0, `readData`=0, memory unchanged.
- WAIT_CYCLES=3, SW 0xCAFEF00D at 0x20 with reset asserted in the second BUSY cycle → state IDLE, `stall`=0; later LW 0x20 returns the prior contents.
- DEPTH_WORDS=1024: SW 0x11111111 at 0x1000 → LW 0x0 returns 0x11111111 (wrap-around).
